// File: rtl/sr_flag_unit_pkg.sv
// Shared definitions for the MSP430 status register (R2) unit:
// SR bit positions, write masks and the delayed-GIE sequencer encodings.
package sr_flag_unit_pkg;

    // Bit positions inside R2
    localparam int SR_C      = 0;
    localparam int SR_Z      = 1;
    localparam int SR_N      = 2;
    localparam int SR_GIE    = 3;
    localparam int SR_CPUOFF = 4;
    localparam int SR_OSCOFF = 5;
    localparam int SR_SCG0   = 6;
    localparam int SR_SCG1   = 7;
    localparam int SR_V      = 8;

    // Bits 15:9 are reserved and must always read back as zero
    localparam logic [15:0] SR_WR_MASK  = 16'h01FF;

    // Interrupt entry clears everything except SCG0
    localparam logic [15:0] SR_INT_KEEP = 16'h0040;

    // Delayed-GIE sequencer states
    typedef enum logic [1:0] {
        GIE_OFF  = 2'd0,
        GIE_PEND = 2'd1,
        GIE_ON   = 2'd2
    } gie_state_t;

    // Which write path produced the next SR value this cycle
    typedef enum logic [1:0] {
        SRC_NONE    = 2'd0,
        SRC_INT_ACK = 2'd1,
        SRC_RETI    = 2'd2,
        SRC_SR_WE   = 2'd3
    } sr_src_t;

endpackage

// File: rtl/sr_flag_unit_gie_seq.sv
// Delayed-GIE sequencer: enabling GIE by an explicit SR write only takes
// effect after the next instruction completes, while RETI restores it
// immediately. Any path that clears GIE drops the enable at once.
module gie_seq
    import sr_flag_unit_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    gie_next,
    input  sr_src_t src,
    input  logic    instr_done,
    output logic    gie_eff
);

    gie_state_t state;

    // State and registered enable move together so gie_eff always equals (state == GIE_ON)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= GIE_OFF;
            gie_eff <= 1'b0;
        end else if ((src == SRC_INT_ACK) || ((src != SRC_NONE) && !gie_next)) begin
            state   <= GIE_OFF;
            gie_eff <= 1'b0;
        end else begin
            case (src)
                SRC_RETI: begin
                    state   <= GIE_ON;
                    gie_eff <= 1'b1;
                end
                SRC_SR_WE: begin
                    if (state == GIE_ON) begin
                        state   <= GIE_ON;
                        gie_eff <= 1'b1;
                    end else begin
                        state   <= GIE_PEND;
                        gie_eff <= 1'b0;
                    end
                end
                default: begin
                    if ((state == GIE_PEND) && instr_done) begin
                        state   <= GIE_ON;
                        gie_eff <= 1'b1;
                    end else if (state == GIE_ON) begin
                        state   <= GIE_ON;
                        gie_eff <= 1'b1;
                    end else if (state == GIE_PEND) begin
                        state   <= GIE_PEND;
                        gie_eff <= 1'b0;
                    end else begin
                        state   <= GIE_OFF;
                        gie_eff <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/sr_flag_unit.sv
// MSP430 status register (R2) sitting behind the ALU. Captures C/Z/N/V under
// per-flag enables, services explicit SR writes, interrupt entry and RETI,
// and hands the delayed-GIE sequencing to gie_seq.
module sr_flag_unit
    import sr_flag_unit_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic            MCLK,
    input  logic            RST_n,
    input  logic [SIZE-1:0] ALU_OUT,
    input  logic            Cout,
    input  logic            Vout,
    input  logic            BW,
    input  logic [3:0]      FLAG_WE,
    input  logic            SR_WE,
    input  logic [SIZE-1:0] SR_DIN,
    input  logic            RETI_LD,
    input  logic [SIZE-1:0] RETI_DIN,
    input  logic            INT_ACK,
    input  logic            INSTR_DONE,
    output logic [SIZE-1:0] SR_OUT,
    output logic            GIE_EFF,
    output logic            CPU_OFF
);

    logic [SIZE-1:0] sr_q;
    logic [SIZE-1:0] sr_next;
    sr_src_t         src;
    logic            z_flag;
    logic            n_flag;

    // Zero and negative follow the operand width of the current instruction
    always_comb begin
        z_flag = 1'b0;
        n_flag = 1'b0;
        if (BW) begin
            z_flag = (ALU_OUT[7:0] == 8'h00);
            n_flag = ALU_OUT[7];
        end else begin
            z_flag = (ALU_OUT == '0);
            n_flag = ALU_OUT[SIZE-1];
        end
    end

    // Prioritised next-SR selection: interrupt entry, RETI, explicit write, then flag capture
    always_comb begin
        sr_next = sr_q;
        src     = SRC_NONE;
        if (INT_ACK) begin
            sr_next = sr_q & SR_INT_KEEP;
            src     = SRC_INT_ACK;
        end else if (RETI_LD) begin
            sr_next = RETI_DIN & SR_WR_MASK;
            src     = SRC_RETI;
        end else if (SR_WE) begin
            sr_next = SR_DIN & SR_WR_MASK;
            src     = SRC_SR_WE;
        end else begin
            if (FLAG_WE[0]) sr_next[SR_C] = Cout;
            if (FLAG_WE[1]) sr_next[SR_Z] = z_flag;
            if (FLAG_WE[2]) sr_next[SR_N] = n_flag;
            if (FLAG_WE[3]) sr_next[SR_V] = Vout;
        end
    end

    // R2 storage; reserved bits can never become set because every source is masked
    always_ff @(posedge MCLK or negedge RST_n) begin
        if (!RST_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_next;
        end
    end

    gie_seq u_gie_seq (
        .clk        (MCLK),
        .rst_n      (RST_n),
        .gie_next   (sr_next[SR_GIE]),
        .src        (src),
        .instr_done (INSTR_DONE),
        .gie_eff    (GIE_EFF)
    );

    assign SR_OUT  = sr_q;
    assign CPU_OFF = sr_q[SR_CPUOFF];

endmodule

// File: doc/sr_flag_unit.md
Name: sr_flag_unit

Overview:
- Holds the MSP430 status register (R2) directly downstream of the ALU, including the logic circuit.
- Captures C/Z/N/V from the ALU result under decoder-supplied update masks.
- Services explicit register-file writes to R2, interrupt entry (SR clear) and RETI restore.
- Owns the delayed-GIE sequencing: an interrupt is not accepted until one instruction after EINT.

Parameters:
SIZE, 16, datapath width of ALU result and SR (only 16 supported).

Ports:
MCLK  in  1  system clock, all state on rising edge.
RST_n  in  1  asynchronous active-low reset.
ALU_OUT  in  SIZE  ALU result (LOG_OUT or arithmetic result, already muxed).
Cout  in  1  ALU carry (for logic ops = Cout_log).
Vout  in  1  ALU overflow.
BW  in  1  1 = byte operation, 0 = word.
FLAG_WE  in  4  per-flag update enable {V,N,Z,C}.
SR_WE  in  1  explicit write of SR_DIN into R2 (MOV/BIS/BIC to SR).
SR_DIN  in  SIZE  data for explicit write.
RETI_LD  in  1  load RETI_DIN (popped SR) into R2.
RETI_DIN  in  SIZE  popped SR value.
INT_ACK  in  1  interrupt accepted this cycle.
INSTR_DONE  in  1  one-cycle strobe at the last cycle of each instruction.
SR_OUT  out  SIZE  current R2 contents.
GIE_EFF  out  1  effective interrupt enable presented to the interrupt controller.
CPU_OFF  out  1  SR_OUT[4].

Behaviour:
- SR bit map: C=0, Z=1, N=2, GIE=3, CPUOFF=4, OSCOFF=5, SCG0=6, SCG1=7, V=8. Bits 15:9 are reserved: always read 0, writes ignored.
- Reset (RST_n=0, async): SR_OUT=0x0000, GIE_EFF=0, CPU_OFF=0, GIE FSM=OFF.
- Flag derivation, combinational from inputs:
  - Z = (BW ? ALU_OUT[7:0] : ALU_OUT) == 0.
  - N = BW ? ALU_OUT[7] : ALU_OUT[15].
  - C = Cout; V = Vout.
- Write priority per cycle, highest first:
  1. INT_ACK: SR <= SR & 0x0040 (only SCG0 kept).
  2. RETI_LD: SR <= RETI_DIN & 0x01FF.
  3. SR_WE: SR <= SR_DIN & 0x01FF. A flag update in the same cycle is discarded.
  4. FLAG_WE: each enabled flag bit takes its derived value; other bits hold.
  5. Otherwise hold.
- Latency: every update is visible on SR_OUT the cycle after the enabling edge. There is no combinational path from inputs to SR_OUT.
- GIE FSM, states OFF / PEND / ON:
  - Any state -> OFF when the new GIE bit = 0 (INT_ACK, RETI_LD or SR_WE clearing it).
  - OFF -> PEND when SR_WE sets GIE.
  - OFF/PEND -> ON when RETI_LD sets GIE (immediate, no delay).
  - PEND -> ON on the first INSTR_DONE strictly after the write cycle. An INSTR_DONE in the same cycle as the write does not count.
  - ON stays ON while GIE=1. SR_WE rewriting GIE=1 while in ON keeps ON.
  - GIE_EFF = (state==ON), registered.
- Simultaneous INT_ACK and INSTR_DONE in PEND: INT_ACK wins and the FSM goes to OFF.
- Reset mid-PEND returns to OFF, with no residual arming.

Decomposition:
- Shared package: SR bit-index constants (SR_C..SR_V), the SR writable mask 0x01FF, the interrupt-entry keep mask 0x0040, and the GIE FSM state encoding.
- One natural sub-module, gie_seq: the three-state GIE FSM. Inputs are the next-GIE bit, a source tag and INSTR_DONE; output is GIE_EFF.

Test Plan:
- Reset: assert RST_n=0 mid-cycle -> SR_OUT=0x0000 and GIE_EFF=0 immediately, without waiting for an MCLK edge.
- Word AND result 0x0000, Cout=0, Vout=0, FLAG_WE=4'b1111, BW=0 -> next cycle SR_OUT=0x0002 (Z only). Then ALU_OUT=0x8000 with Cout=1 -> SR_OUT=0x0005.
- Byte mode ALU_OUT=0x1200, BW=1, FLAG_WE=4'b0110 -> Z=1, N=0, C/V unchanged. Same value with BW=0 -> Z=0.
- SR_WE with SR_DIN=0xFFFF and FLAG_WE=4'b1111 in the same cycle -> SR_OUT=0x01FF (reserved bits cleared, flags ignored); GIE FSM goes to PEND.
- EINT timing: SR_WE sets GIE with INSTR_DONE in the same cycle -> GIE_EFF stays 0; the next INSTR_DONE -> GIE_EFF=1 one cycle later.
- With SR=0x01F8 and GIE_EFF=1, pulse INT_ACK -> SR_OUT=0x0040, GIE_EFF=0. Then RETI_LD with RETI_DIN=0x0108 -> SR_OUT=0x0108 and GIE_EFF=1 the next cycle, with no INSTR_DONE needed.
